adder_bist_checker: RTL
=======================

# adder_bist_checker

Hardware self-test engine for the 4-bit carry-lookahead adder (Vr74x283 pin interface). It drives every one of the 512 {CI, B, A} input combinations into the adder, reads back S3..S0/CO, compares each result against a built-in expected sum, and reports a pass/fail verdict, an error count and the first failing vector. It sits between the board-level control (start button/LEDs) and the adder instance, replacing the simulation-only stimulus bench with an on-chip checker.

## Interface

- SETTLE, default 1: extra idle cycles between driving a vector and sampling the result (legal 0..15).

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle (or held) request to run a full test; sampled only in IDLE or DONE
- a_o  output  4  to adder A3..A0 (a_o[0] = A0)
- b_o  output  4  to adder B3..B0
- ci_o  output  1  to adder CI
- s_i  input  4  from adder S3..S0
- co_i  input  1  from adder CO
- busy  output  1  high while a test is running
- done  output  1  high (level) once a test has completed, until the next start or reset
- pass  output  1  valid when done=1: 1 iff err_cnt == 0
- err_cnt  output  10  number of mismatching vectors in the current/last run (0..512)
- fail_valid  output  1  high once the first mismatch of the run has been captured
- fail_idx  output  9  vector index {ci, b, a} of the first mismatch
- fail_got  output  5  observed {co_i, s_i} at the first mismatch

## Operation

- Vector index idx[8:0]: a_o = idx[3:0], b_o = idx[7:4], ci_o = idx[8]; a_o/b_o/ci_o are driven straight from the idx register.
- Expected result: 5-bit exp = a_o + b_o + ci_o (zero-extended, no truncation); compared with {co_i, s_i}.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
  - IDLE: busy=0, done=0. start=1 -> clear idx, err_cnt, fail_valid, fail_idx, fail_got; go APPLY.
  - APPLY: 1 cycle; vector is on the pins. Go WAIT if SETTLE>0, else CHECK.
  - WAIT: count SETTLE cycles, then CHECK.
  - CHECK: 1 cycle; compare. On mismatch err_cnt += 1; if fail_valid=0 capture fail_idx=idx, fail_got={co_i,s_i}, set fail_valid. If idx==511 go DONE (idx holds 511); else idx += 1, go APPLY.
  - DONE: busy=0, done=1, results held. start=1 -> same clear as IDLE, go APPLY (restart).
- start in APPLY/WAIT/CHECK is ignored.
- err_cnt never exceeds 512; no saturation logic needed.

## Timing

- Reset (rst=1 at a clock edge): state=IDLE, idx=0 (so a_o=0, b_o=0, ci_o=0), busy=0, done=0, pass=1, err_cnt=0, fail_valid=0, fail_idx=0, fail_got=0. Reset mid-run aborts immediately with these values; no partial results retained.
- start sampled high at edge T0 -> busy=1 and state=APPLY from T0 onward, idx=0.
- Each vector takes exactly 2+SETTLE cycles (APPLY, SETTLE x WAIT, CHECK).
- Adder result is sampled in CHECK, i.e. SETTLE+1 cycles after the vector appears on the pins.
- done rises, and busy falls, at the edge 512*(2+SETTLE) cycles after T0; pass/err_cnt/fail_* are stable from that edge.
- pass is combinational from err_cnt; it equals 1 during IDLE after reset.
- err_cnt and fail_* update at the CHECK edge; they are visible mid-run.

## Test plan

- Ideal adder model, SETTLE=1, pulse start -> busy for 1536 cycles, done=1, pass=1, err_cnt=0, fail_valid=0; last vector on pins a_o=F, b_o=F, ci_o=1.
- Model with S0 stuck at 0 -> err_cnt=256, pass=0, fail_idx=0x001, fail_got=5'b00000.
- Model with CO stuck at 0 -> err_cnt=256, fail_idx=0x01F (a=F, b=1, ci=0), fail_got=5'b00000.
- SETTLE=0 with a model that has 1-cycle registered output -> every vector with a differing sum fails (err_cnt>0); the same model with SETTLE=1 -> pass=1.
- Assert rst during vector idx=100 -> next cycle all outputs at reset values; a new start then runs all 512 vectors from idx=0.
- Pulse start during busy -> ignored (finish time unchanged); start in DONE -> counters clear, run repeats with identical results.

Source files
------------

// File: rtl/adder_bist_checker_if.sv
// Bundle of signals between the adder self-test engine, the adder under test
// and the board-level start/status logic.
// The master modport is the checker's view. The slave modport is the view of
// the adder and board side.
interface adder_bist_checker_if;
  // board control
  logic       start;
  // adder pins
  logic [3:0] a_o;
  logic [3:0] b_o;
  logic       ci_o;
  logic [3:0] s_i;
  logic       co_i;
  // status
  logic       busy;
  logic       done;
  logic       pass;
  logic [9:0] err_cnt;
  logic       fail_valid;
  logic [8:0] fail_idx;
  logic [4:0] fail_got;

  modport master (
    input  start, s_i, co_i,
    output a_o, b_o, ci_o, busy, done, pass, err_cnt, fail_valid, fail_idx, fail_got
  );

  modport slave (
    output start, s_i, co_i,
    input  a_o, b_o, ci_o, busy, done, pass, err_cnt, fail_valid, fail_idx, fail_got
  );
endinterface

// File: rtl/adder_bist_checker.sv
// Built-in self-test engine for a 4-bit carry-lookahead adder.
// It walks all 512 {ci, b, a} combinations. The adder result for each vector
// is captured on the edge that enters CHECK, which is SETTLE+1 cycles after
// the vector reaches the pins. CHECK compares the captured result against
// the built-in sum, then counts the mismatch and records the first failure.
module adder_bist_checker #(
  parameter int unsigned SETTLE = 1
) (
  input logic                  clk,
  input logic                  rst,
  adder_bist_checker_if.master bus
);

  localparam logic       HAS_WAIT    = (SETTLE > 0);
  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 32'd1);
  localparam logic [8:0] LAST_IDX    = 9'd511;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    APPLY = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [8:0] idx;
  logic [3:0] wait_cnt;
  logic [4:0] sample;
  logic [9:0] err_cnt;
  logic       fail_valid;
  logic [8:0] fail_idx;
  logic [4:0] fail_got;
  logic       busy;
  logic       done;
  logic       mismatch;

  // Reference sum for a vector index {ci, b, a}, widened so the carry is kept.
  function automatic logic [4:0] expected_sum(input logic [8:0] v);
    return {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0000, v[8]};
  endfunction

  // Compare the captured adder result against the reference sum.
  always_comb begin
    mismatch = 1'b0;
    if (sample != expected_sum(idx)) begin
      mismatch = 1'b1;
    end else begin
      mismatch = 1'b0;
    end
  end

  // Next-state logic of the test sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) state_next = APPLY;
        else           state_next = IDLE;
      end
      APPLY: begin
        if (HAS_WAIT) state_next = WAIT;
        else          state_next = CHECK;
      end
      WAIT: begin
        if (wait_cnt == SETTLE_LAST) state_next = CHECK;
        else                         state_next = WAIT;
      end
      CHECK: begin
        if (idx == LAST_IDX) state_next = DONE;
        else                 state_next = APPLY;
      end
      DONE: begin
        if (bus.start) state_next = APPLY;
        else           state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state, vector index, result capture and the error bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 9'd0;
      wait_cnt   <= 4'd0;
      sample     <= 5'd0;
      err_cnt    <= 10'd0;
      fail_valid <= 1'b0;
      fail_idx   <= 9'd0;
      fail_got   <= 5'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == APPLY) || (state_next == WAIT) || (state_next == CHECK);
      done  <= (state_next == DONE);
      // The adder output is latched when CHECK is entered, which is after the settle time.
      if (state_next == CHECK) begin
        sample <= {bus.co_i, bus.s_i};
      end
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            idx        <= 9'd0;
            err_cnt    <= 10'd0;
            fail_valid <= 1'b0;
            fail_idx   <= 9'd0;
            fail_got   <= 5'd0;
          end
        end
        APPLY: begin
          wait_cnt <= 4'd0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 4'd1;
        end
        CHECK: begin
          if (mismatch) begin
            err_cnt <= err_cnt + 10'd1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_idx   <= idx;
              fail_got   <= sample;
            end
          end
          // After the last vector, the index stays at 511.
          if (idx != LAST_IDX) begin
            idx <= idx + 9'd1;
          end
        end
        default: begin
          idx <= idx;
        end
      endcase
    end
  end

  // The vector is driven straight from the index register.
  assign bus.a_o        = idx[3:0];
  assign bus.b_o        = idx[7:4];
  assign bus.ci_o       = idx[8];
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = (err_cnt == 10'd0);
  assign bus.err_cnt    = err_cnt;
  assign bus.fail_valid = fail_valid;
  assign bus.fail_idx   = fail_idx;
  assign bus.fail_got   = fail_got;

endmodule
